mpe_job_sequencer: RTL and testbench

Job-level controller for one matrix PE (MPE) instance. It accepts a tile job of K-chunk count, precision mode and operand base addresses. It streams the operand-buffer read addresses, gates the MPE operand ports to zero outside the job, and pulses the MPE end-of-accumulation strobe. It then captures the MPE result and holds it for a valid/ready consumer. It sits between the tile dispatcher and the MPE, and its operand buffers are its only memories.

---
 rtl/mpe_job_sequencer_pkg.sv | 37 +++
 rtl/mpe_job_sequencer_addr_gen.sv | 58 +++++
 rtl/mpe_job_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_mpe_job_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpe_job_sequencer_pkg.sv
// Shared types and constants for the MPE job sequencer.
// Holds the sequencer state encoding, MPE precision-mode codes, the fp16
// lane width and the job-command record captured on accept.
package mpe_job_sequencer_pkg;

    // Width of one MPE result element (fp16)
    localparam int FP16_W = 16;

    // Field widths of the job record; sized for the widest supported job
    // so the record does not depend on a particular instance's parameters.
    localparam int JOB_KLEN_MAX_W = 16;
    localparam int JOB_ADDR_MAX_W = 16;

    // Precision-mode codes as interpreted by the MPE operand shifters
    localparam logic [1:0] MODE_INT8 = 2'b00;
    localparam logic [1:0] MODE_INT4 = 2'b01;
    localparam logic [1:0] MODE_FP16 = 2'b10;
    localparam logic [1:0] MODE_FP8  = 2'b11;

    // Job-level controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_HOLD     = 3'd4
    } seq_state_t;

    // Job command as registered on accept
    typedef struct packed {
        logic [JOB_KLEN_MAX_W-1:0] k_len;
        logic [1:0]                mode;
        logic [JOB_ADDR_MAX_W-1:0] a_base;
        logic [JOB_ADDR_MAX_W-1:0] b_base;
    } job_cmd_t;

endpackage

// File: rtl/mpe_job_sequencer_addr_gen.sv
// Operand-buffer address generator for the MPE job sequencer.
// After a start pulse it raises rd_en for exactly k_len consecutive cycles
// with addresses base+i (wrapping at the address width), then pulses done
// on the cycle the last operand word reaches the MPE (one cycle after the
// final read, matching the buffer's one-cycle read latency).
module mpe_seq_addr_gen
    import mpe_job_sequencer_pkg::*;
#(
    parameter int KLEN_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KLEN_W-1:0] k_len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              done
);

    logic [KLEN_W-1:0] idx_reg;
    logic              active_reg;
    logic              done_reg;
    logic              last_issue;

    // Final read of the job is being issued this cycle
    assign last_issue = active_reg && (idx_reg == (k_len - KLEN_W'(1)));

    // Issue-length counter; a start pulse restarts the chunk index at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg    <= '0;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= last_issue;
            if (start) begin
                active_reg <= 1'b1;
                idx_reg    <= '0;
            end else if (active_reg) begin
                if (last_issue) begin
                    active_reg <= 1'b0;
                end else begin
                    idx_reg <= idx_reg + KLEN_W'(1);
                end
            end
        end
    end

    assign rd_en     = active_reg;
    assign rd_addr_a = a_base + ADDR_W'(idx_reg);
    assign rd_addr_b = b_base + ADDR_W'(idx_reg);
    assign done      = done_reg;

endmodule

// File: rtl/mpe_job_sequencer.sv
// Job-level controller for one matrix PE instance.
// Accepts a tile job, streams operand-buffer reads, zero-gates the MPE
// operand ports outside the job's data window, strobes end-of-accumulation,
// then captures and holds the MPE result for a valid/ready consumer.
// Optional build macro: MPE_SEQ_PERF_EN adds saturating perf_jobs and
// perf_stall counters.
module mpe_job_sequencer
    import mpe_job_sequencer_pkg::*;
#(
    parameter int DIM1        = 2,
    parameter int DIM2        = 1,
    parameter int KLEN_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int OUT_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [KLEN_W-1:0]             cmd_k_len,
    input  logic [1:0]                    cmd_mode,
    input  logic [ADDR_W-1:0]             cmd_a_base,
    input  logic [ADDR_W-1:0]             cmd_b_base,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr_a,
    output logic [ADDR_W-1:0]             rd_addr_b,
    output logic                          mpe_op_zero,
    output logic                          mpe_in_valid,
    output logic [1:0]                    mpe_mode,
    input  logic                          mpe_out_valid,
    input  logic [DIM1*DIM2*FP16_W-1:0]   mpe_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DIM1*DIM2*FP16_W-1:0]   res_data,
    output logic                          busy,
    output logic [1:0]                    err
`ifdef MPE_SEQ_PERF_EN
    ,
    output logic [31:0]                   perf_jobs,
    output logic [31:0]                   perf_stall
`endif
);

    localparam int LANES = DIM1 * DIM2;
    localparam int TO_W  = $clog2(OUT_TIMEOUT + 2);

    seq_state_t       state_reg, state_next;
    job_cmd_t         cmd_job;
    job_cmd_t         job_reg;
    logic             accept;
    logic             start;
    logic             issue_done;
    logic             capture;
    logic             release_res;
    logic             timeout_hit;
    logic [TO_W-1:0]  tcnt_reg;
    logic [1:0]       err_reg;
    logic             res_valid_reg;
    logic             op_zero_reg;
    logic             unused_job_hi;

    assign accept      = cmd_valid && (state_reg == ST_IDLE);
    assign start       = accept && (cmd_k_len != '0);
    assign capture     = (state_reg == ST_WAIT_OUT) && mpe_out_valid;
    assign release_res = (state_reg == ST_HOLD) && res_ready;
    assign timeout_hit = (state_reg == ST_WAIT_OUT) && !mpe_out_valid
                         && (tcnt_reg == TO_W'(OUT_TIMEOUT));

    // Pack the offered command into the job record (unused high bits zero)
    always_comb begin
        cmd_job                     = '0;
        cmd_job.k_len[KLEN_W-1:0]   = cmd_k_len;
        cmd_job.mode                = cmd_mode;
        cmd_job.a_base[ADDR_W-1:0]  = cmd_a_base;
        cmd_job.b_base[ADDR_W-1:0]  = cmd_b_base;
    end

    // High bits of the record are always zero for this instance
    assign unused_job_hi = |(job_reg.k_len >> KLEN_W)
                         | |(job_reg.a_base >> ADDR_W)
                         | |(job_reg.b_base >> ADDR_W);

    // Job register: loaded on every accept, so mpe_mode only moves there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_reg <= '0;
        end else if (accept) begin
            job_reg <= cmd_job;
        end
    end

    mpe_seq_addr_gen #(
        .KLEN_W (KLEN_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (job_reg.k_len[KLEN_W-1:0]),
        .a_base    (job_reg.a_base[ADDR_W-1:0]),
        .b_base    (job_reg.b_base[ADDR_W-1:0]),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .done      (issue_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and state-decoded outputs; ISSUE lasts until the last
    // operand word has been presented, so DRAIN strobes right after it
    always_comb begin
        state_next   = state_reg;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        mpe_in_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (start) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_done) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mpe_in_valid = 1'b1;
                state_next   = ST_WAIT_OUT;
            end
            ST_WAIT_OUT: begin
                if (capture) begin
                    state_next = ST_HOLD;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (release_res) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Timeout counter: counts cycles since the strobe while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_reg <= '0;
        end else if (state_reg == ST_DRAIN) begin
            tcnt_reg <= TO_W'(1);
        end else if (state_reg == ST_WAIT_OUT) begin
            tcnt_reg <= tcnt_reg + TO_W'(1);
        end
    end

    // Operand gating: data arrives one cycle after each read enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_zero_reg <= 1'b1;
        end else begin
            op_zero_reg <= ~rd_en;
        end
    end

    // Sticky error flags and result-valid handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg       <= 2'b00;
            res_valid_reg <= 1'b0;
        end else begin
            if (accept && (cmd_k_len == '0)) begin
                err_reg[0] <= 1'b1;
            end
            if (timeout_hit) begin
                err_reg[1] <= 1'b1;
            end
            if (capture) begin
                res_valid_reg <= 1'b1;
            end else if (release_res) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    // Result capture, one fp16 lane per generated register
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [FP16_W-1:0] lane_reg;

        // Hold the lane stable from capture until the next capture
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_reg <= '0;
            end else if (capture) begin
                lane_reg <= mpe_out[gi*FP16_W +: FP16_W];
            end
        end

        assign res_data[gi*FP16_W +: FP16_W] = lane_reg;
    end

`ifdef MPE_SEQ_PERF_EN
    logic [31:0] perf_jobs_reg;
    logic [31:0] perf_stall_reg;

    // Saturating counters: completed result handshakes and HOLD stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (release_res && (perf_jobs_reg != '1)) begin
                perf_jobs_reg <= perf_jobs_reg + 32'd1;
            end
            if ((state_reg == ST_HOLD) && !res_ready && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_jobs  = perf_jobs_reg;
    assign perf_stall = perf_stall_reg;
`endif

    assign mpe_mode    = job_reg.mode;
    assign mpe_op_zero = op_zero_reg;
    assign res_valid   = res_valid_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_mpe_job_sequencer.sv
// Self-checking bench for mpe_job_sequencer. Expected behaviour is derived
// per job from cycle offsets relative to the accept cycle.
module tb_mpe_job_sequencer;
    import mpe_job_sequencer_pkg::*;

    localparam int OUT_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_k_len = '0;
    logic [1:0]  cmd_mode = '0;
    logic [9:0]  cmd_a_base = '0;
    logic [9:0]  cmd_b_base = '0;
    logic        rd_en;
    logic [9:0]  rd_addr_a;
    logic [9:0]  rd_addr_b;
    logic        mpe_op_zero;
    logic        mpe_in_valid;
    logic [1:0]  mpe_mode;
    logic        mpe_out_valid = 1'b0;
    logic [31:0] mpe_out = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        busy;
    logic [1:0]  err;
`ifdef MPE_SEQ_PERF_EN
    logic [31:0] perf_jobs;
    logic [31:0] perf_stall;
`endif

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [1:0]  err_exp = 2'b00;
    int          last_valid_cyc = 0;
    int          last_first_rd_cyc = 0;

    mpe_job_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_k_len     (cmd_k_len),
        .cmd_mode      (cmd_mode),
        .cmd_a_base    (cmd_a_base),
        .cmd_b_base    (cmd_b_base),
        .rd_en         (rd_en),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .mpe_op_zero   (mpe_op_zero),
        .mpe_in_valid  (mpe_in_valid),
        .mpe_mode      (mpe_mode),
        .mpe_out_valid (mpe_out_valid),
        .mpe_out       (mpe_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy),
        .err           (err)
`ifdef MPE_SEQ_PERF_EN
        ,
        .perf_jobs     (perf_jobs),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One job from accept to return-to-IDLE. Offsets t count cycles after
    // the accept cycle: reads at 1..k, operand data at 2..k+1, strobe at
    // k+2, MPE answer at strobe+lat, result held until the consumer takes
    // it after `hold` stalled cycles. Without an answer the job must give
    // up OUT_TIMEOUT cycles after the strobe.
    task automatic run_job(input int k, input logic [9:0] a, input logic [9:0] b,
                           input logic [1:0] mode, input int lat, input int hold,
                           input logic [31:0] data, input bit respond,
                           input bit keep_valid, input string name);
        int         s_t, v_t, end_t;
        bit         exp_rd, exp_rv, exp_busy;
        logic [7:0] obs, expv;
        logic [9:0] ea, eb;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept_ready got=%b exp=1", name, cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_k_len  = 8'(k);
        cmd_mode   = mode;
        cmd_a_base = a;
        cmd_b_base = b;
        s_t   = k + 2;
        v_t   = s_t + lat;
        end_t = respond ? (v_t + hold + 2) : (s_t + OUT_TIMEOUT + 1);
        for (int t = 1; t <= end_t; t++) begin
            @(negedge clk);
            if (t == 1) begin
                last_first_rd_cyc = cyc;
                if (!keep_valid) cmd_valid = 1'b0;
            end
            if (t == end_t && !respond) err_exp[1] = 1'b1;
            exp_rd   = (t <= k);
            exp_rv   = respond && (t > v_t) && (t <= v_t + hold + 1);
            exp_busy = (t < end_t);
            expv = {exp_rd, !(t >= 2 && t <= k + 1), (t == s_t), exp_busy,
                    !exp_busy, exp_rv, err_exp};
            obs  = {rd_en, mpe_op_zero, mpe_in_valid, busy, cmd_ready, res_valid, err};
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s ctrl t=%0d got=%b exp=%b (rd,opz,strb,busy,rdy,rv,err)",
                         name, t, obs, expv);
            end
            if (exp_rd) begin
                ea = a + 10'(t - 1);
                eb = b + 10'(t - 1);
                tests++;
                if ({rd_addr_a, rd_addr_b} !== {ea, eb}) begin
                    fails++;
                    $display("FAIL %s addr t=%0d got=%h/%h exp=%h/%h",
                             name, t, rd_addr_a, rd_addr_b, ea, eb);
                end
            end
            if (exp_rv) begin
                tests++;
                if (res_data !== data) begin
                    fails++;
                    $display("FAIL %s res_data t=%0d got=%h exp=%h", name, t, res_data, data);
                end
            end
            tests++;
            if (mpe_mode !== mode) begin
                fails++;
                $display("FAIL %s mpe_mode t=%0d got=%b exp=%b", name, t, mpe_mode, mode);
            end
            // MPE model: true answer at v_t, spurious pulses outside WAIT_OUT
            if (respond && t == v_t) begin
                mpe_out_valid  = 1'b1;
                mpe_out        = data;
                last_valid_cyc = cyc;
            end else begin
                mpe_out_valid = (t < s_t || (respond && t > v_t && t < end_t))
                                && ($urandom_range(0, 3) == 0);
                mpe_out       = $urandom;
            end
            // Consumer: random ready before the result exists, then stall
            if (respond && t > v_t)
                res_ready = (t == v_t + hold + 1);
            else
                res_ready = 1'($urandom_range(0, 1));
            if (t == end_t) begin
                mpe_out_valid = 1'b0;
                res_ready     = 1'b0;
            end
        end
        $display("[TB] job %s k=%0d a=%h b=%h mode=%b lat=%0d hold=%0d resp=%0d",
                 name, k, a, b, mode, lat, hold, respond);
    endtask

    task automatic test_reset();
        logic [60:0] obs, expv;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs  = {rd_en, mpe_op_zero, mpe_in_valid, busy, res_valid, err, mpe_mode,
                res_data, rd_addr_a, rd_addr_b};
        expv = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 10'h0, 10'h0};
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL reset_values got=%h exp=%h", obs, expv);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({cmd_ready, busy} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release_idle got=%b exp=10", {cmd_ready, busy});
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_wrap_hold();
        run_job(4, 10'h3FE, 10'h010, MODE_INT4, 2, 5, 32'h3C00_4000, 1'b1, 1'b0, "wrap_hold");
    endtask

    task automatic test_zero_len();
        cmd_valid = 1'b1;
        cmd_k_len = 8'd0;
        cmd_mode  = MODE_FP16;
        @(negedge clk);
        cmd_valid  = 1'b0;
        err_exp[0] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tests++;
            if ({rd_en, mpe_in_valid, busy, cmd_ready, res_valid, err} !== {4'b0001, 1'b0, err_exp}) begin
                fails++;
                $display("FAIL zero_len t=%0d got=%b exp=%b", t,
                         {rd_en, mpe_in_valid, busy, cmd_ready, res_valid, err},
                         {4'b0001, 1'b0, err_exp});
            end
            @(negedge clk);
        end
        $display("[TB] zero-length job checked err=%b", err);
    endtask

    task automatic test_back_to_back();
        int first_valid;
        run_job(5, 10'h100, 10'h200, MODE_INT4, 2, 0, 32'h1234_5678, 1'b1, 1'b1, "b2b_first");
        first_valid = last_valid_cyc;
        run_job(3, 10'h3FF, 10'h0F0, MODE_FP8, 2, 0, 32'hBEEF_0001, 1'b1, 1'b0, "b2b_second");
        tests++;
        if (last_first_rd_cyc - first_valid < 2) begin
            fails++;
            $display("FAIL b2b_spacing got=%0d exp>=2", last_first_rd_cyc - first_valid);
        end
        $display("[TB] back-to-back spacing=%0d", last_first_rd_cyc - first_valid);
    endtask

    task automatic test_timeout();
        run_job(3, 10'h050, 10'h060, MODE_INT8, 0, 0, 32'h0, 1'b0, 1'b0, "timeout");
    endtask

    task automatic test_random_jobs();
        bit chain;
        for (int i = 0; i < 12; i++) begin
            chain = (i < 11) && ($urandom_range(0, 1) == 1);
            run_job($urandom_range(1, 12), 10'($urandom), 10'($urandom), 2'($urandom),
                    $urandom_range(1, 6), $urandom_range(0, 4), $urandom, 1'b1, chain, "random");
            if (!chain) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [60:0] obs, expv;
        cmd_valid  = 1'b1;
        cmd_k_len  = 8'd8;
        cmd_mode   = MODE_FP8;
        cmd_a_base = 10'h155;
        cmd_b_base = 10'h2AA;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (rd_en !== 1'b1) begin
            fails++;
            $display("FAIL midjob_issuing got=%b exp=1", rd_en);
        end
        #2 rst_n = 1'b0;
        #1;
        err_exp = 2'b00;
        obs  = {rd_en, mpe_op_zero, mpe_in_valid, busy, res_valid, err, mpe_mode,
                res_data, rd_addr_a, rd_addr_b};
        expv = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 10'h0, 10'h0};
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL midjob_reset_values got=%h exp=%h", obs, expv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            tests++;
            if ({rd_en, mpe_in_valid, busy, mpe_op_zero, res_valid} !== 5'b00010) begin
                fails++;
                $display("FAIL midjob_after_release t=%0d got=%b exp=00010", t,
                         {rd_en, mpe_in_valid, busy, mpe_op_zero, res_valid});
            end
        end
        $display("[TB] reset mid-job checked");
    endtask

    initial begin
        test_reset();
        test_wrap_hold();
        test_zero_len();
        test_back_to_back();
        test_timeout();
        test_random_jobs();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
